mul12u_rr_sched: RTL and testbench
==================================

# mul12u_rr_sched

Round-robin scheduler that shares one 12x12 unsigned multiplier among `NREQ` requesters, with per-request precision selection.
- Approximate mode truncates the `TRUNC` operand LSBs (the low-power approximate mode); exact mode uses full operands.
- Each request uses a valid/ready handshake. The block arbitrates, computes the product and pipelines it through `LAT` register stages.
- Results come back tagged with the requester ID on a single backpressured response port.
- It sits between several accelerator lanes and the single shared multiplier resource.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters, 2..8.
- `W`, 12 — operand width; the product is `2*W`.
- `TRUNC`, 7 — operand LSBs zeroed in approximate mode, 0..`W`-1.
- `LAT`, 2 — result register stages, 1..4.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in `NREQ` — request pending, one bit per requester.
- `req_ready` out `NREQ` — request accepted this cycle (one-hot or zero).
- `req_a` in `NREQ*W` — operand A; requester i uses `[i*W +: W]`.
- `req_b` in `NREQ*W` — operand B, same packing as `req_a`.
- `req_exact` in `NREQ` — 1 = exact product, 0 = approximate.
- `rsp_valid` out 1 — result valid.
- `rsp_ready` in 1 — downstream accepts the result.
- `rsp_id` out `$clog2(NREQ)` — requester index of the result.
- `rsp_z` out `2*W` — product.

## Operation
- **Precision.** Masked operand `A' = exact ? A : {A[W-1:TRUNC], TRUNC'b0}`; `B'` is formed the same way.
  - `Z = A' * B'`, unsigned, full `2*W` bits, no rounding or saturation.
- **Arbitration.** Round-robin with pointer `ptr` (reset 0).
  - Grant goes to the first i with `req_valid[i]`, searching `ptr, ptr+1, …` modulo `NREQ`.
  - After a grant to g, `ptr <= (g+1) mod NREQ`.
  - With no grant, `ptr` holds.
- **Advance.** `adv = !(rsp_valid && !rsp_ready)`; the whole pipeline moves only when `adv=1`.
- **Ready.** `req_ready[i] = adv && grant[i]`.
  - This is combinational from `req_valid`, `ptr` and the output-stage state.
  - A requester holds `req_a`, `req_b` and `req_exact` stable while `req_valid` is high and `req_ready` is low.
  - A requester may drop `req_valid` at any time before acceptance.
- **Pipeline.**
  - On acceptance, `{1, g, Z}` is computed combinationally and loaded into stage 1.
  - Stages 2..`LAT` shift on `adv`; stage `LAT` drives `rsp_valid`, `rsp_id` and `rsp_z`.
  - When `adv=1` and there is no grant, a bubble (valid=0) enters stage 1.
- **Output hold.** While `rsp_valid=1` and `rsp_ready=0`, `rsp_id` and `rsp_z` hold stable.
  - All stages freeze. No data is dropped or duplicated.
- **Ordering.** Responses leave in acceptance order.
- **Reset.** On `rst=1` at a clock edge:
  - all stage valids clear, `ptr=0`, and `rsp_valid=0`, `rsp_id=0`, `rsp_z=0` from the next cycle;
  - in-flight results are discarded;
  - `req_ready` is 0 during any cycle with `rst=1`.
- **Data stage registers** also reset to 0.

## Timing
- Accept at edge t (`req_valid[i] && req_ready[i]`) → `rsp_valid=1` with that result from edge t+`LAT`, if `rsp_ready` stayed 1.
- Each cycle with `rsp_valid && !rsp_ready` adds one cycle of latency to every in-flight item.
- **Throughput:** one accept per cycle under `rsp_ready=1`. With all requesters valid, requester i gets exactly one grant every `NREQ` cycles.
- **Simultaneous events:**
  - With `rsp_ready=0` and the output full, there is no grant, even if earlier stages hold bubbles (no bubble collapsing).
  - A result leaving (`rsp_ready=1`) and a new grant occur in the same cycle.
- **`ptr` wrap:** after a grant to `NREQ-1`, `ptr` becomes 0.

## Test plan
- **Approximate max**, `req_exact=0`, A=B=0xFFF, `LAT=2`: accept at t → `rsp_z=0xF04000` at t+2. With `req_exact=1` → `0xFFE001`.
- **Truncation floor**, approx, A=B=0x07F → `rsp_z=0x000000`. Approx A=B=0x080 → `0x004000`. Exact A=0x07F, B=0x07F → `0x003F01`.
- **Round-robin**, all 4 `req_valid=1` continuously, `rsp_ready=1` → `req_ready` one-hot sequence 0,1,2,3,0,1.
  - `rsp_id` follows the same sequence delayed by 2 cycles.
  - Only requesters 1 and 3 valid → grants alternate 1,3,1,3.
- **Backpressure**, `rsp_ready=0` for 3 cycles with `rsp_valid=1`:
  - `rsp_z`/`rsp_id` are stable;
  - `req_ready` is all-zero;
  - after release, all queued results emerge in order with no loss or duplicates.
- **Reset mid-operation**, pipeline full, `rst` pulsed for 1 cycle:
  - next cycle `rsp_valid=0`, `rsp_z=0`;
  - the first grant afterwards goes to requester 0 when all are valid.
- **Dropped request**, requester 2 raises `req_valid` then lowers it before grant (others busy) → no response with `rsp_id=2` ever appears.

Source files
------------

// File: rtl/mul12u_rr_sched.sv
// ---------------------------------------------------------------------------
// mul12u_rr_sched
//
// Shares one W x W unsigned multiplier among NREQ requesters. A round-robin
// arbiter picks at most one request per cycle. The product (exact, or with
// the TRUNC operand LSBs zeroed in approximate mode) goes into a LAT-deep
// result pipeline. The pipeline stalls as a whole when the response port is
// backpressured.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   [NREQ]      request pending, one bit per requester
//   req_ready  out  [NREQ]      request accepted this cycle (one-hot or zero)
//   req_a      in   [NREQ*W]    operand A, requester i at [i*W +: W]
//   req_b      in   [NREQ*W]    operand B, same packing
//   req_exact  in   [NREQ]      1 = exact product, 0 = approximate
//   rsp_valid  out              result valid
//   rsp_ready  in               downstream accepts the result
//   rsp_id     out  [IDW]       requester index of the result
//   rsp_z      out  [2*W]       product
// ---------------------------------------------------------------------------
module mul12u_rr_sched #(
    parameter  int NREQ  = 4,
    parameter  int W     = 12,
    parameter  int TRUNC = 7,
    parameter  int LAT   = 2,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ-1:0]     req_exact,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_z
);

    // Approximate mode keeps only the operand bits above TRUNC.
    localparam logic [W-1:0] APPROX_MASK = ~((W'(1) << TRUNC) - W'(1));

    // Round-robin pointer: first requester examined in the next search.
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;

    // Result pipeline; index 0 is stage 1, index LAT-1 drives the port.
    logic            valid_q [LAT];
    logic [IDW-1:0]  id_q    [LAT];
    logic [2*W-1:0]  z_q     [LAT];

    logic            adv;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic            exact_sel;
    logic [W-1:0]    a_m;
    logic [W-1:0]    b_m;
    logic [2*W-1:0]  z_d;

    // The pipeline moves only when the output stage is empty or being drained.
    // A full output stage under backpressure blocks grants even when earlier
    // stages hold bubbles.
    assign adv = !(valid_q[LAT-1] && !rsp_ready);

    // Rotating priority search starting at ptr_q.
    // NOTE: every variable assigned in always_comb gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        grant     = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[IDW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
        if (gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign accept    = adv && gnt_found && !rst;
    assign req_ready = (adv && !rst) ? grant : '0;

    // Operand mux for the granted requester.
    always_comb begin
        a_sel     = '0;
        b_sel     = '0;
        exact_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_sel     = req_a[i*W +: W];
                b_sel     = req_b[i*W +: W];
                exact_sel = req_exact[i];
            end
        end
    end

    assign a_m = exact_sel ? a_sel : (a_sel & APPROX_MASK);
    assign b_m = exact_sel ? b_sel : (b_sel & APPROX_MASK);
    assign z_d = {{W{1'b0}}, a_m} * {{W{1'b0}}, b_m};

    // The pointer moves past the requester that was just served and wraps.
    assign ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            // NOTE: the data stage registers are cleared along with the
            // valids so rsp_id/rsp_z read zero after reset, not stale data.
            for (int s = 0; s < LAT; s++) begin
                valid_q[s] <= 1'b0;
                id_q[s]    <= '0;
                z_q[s]     <= '0;
            end
        end else if (adv) begin
            // With no grant a bubble enters stage 1. The data lanes load
            // regardless because only the valid bit qualifies them.
            valid_q[0] <= accept;
            id_q[0]    <= gnt_idx;
            z_q[0]     <= z_d;
            for (int s = 1; s < LAT; s++) begin
                valid_q[s] <= valid_q[s-1];
                id_q[s]    <= id_q[s-1];
                z_q[s]     <= z_q[s-1];
            end
            if (accept) begin
                ptr_q <= ptr_d;
            end
        end
    end

    assign rsp_valid = valid_q[LAT-1];
    assign rsp_id    = id_q[LAT-1];
    assign rsp_z     = z_q[LAT-1];

endmodule

// File: tb/tb_mul12u_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_mul12u_rr_sched
//
// Self-checking bench for mul12u_rr_sched. A negedge monitor keeps a
// reference model: a queue of in-flight results, each carrying the number of
// pipeline moves since acceptance, plus a round-robin pointer. It checks
// req_ready, rsp_valid, rsp_id and rsp_z every cycle. Scenario tasks add
// directed checks for precision, arbitration order, backpressure, reset and
// dropped requests. A random phase follows them.
// ---------------------------------------------------------------------------
module tb_mul12u_rr_sched;

    localparam int NREQ  = 4;
    localparam int W     = 12;
    localparam int TRUNC = 7;
    localparam int LAT   = 2;
    localparam int IDW   = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     req_exact;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [2*W-1:0]      rsp_z;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp2_seen = 0;

    mul12u_rr_sched #(.NREQ(NREQ), .W(W), .TRUNC(TRUNC), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_exact (req_exact),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int             id;
        logic [2*W-1:0] z;
        int             age;   // pipeline moves since acceptance
    } item_t;

    item_t m_q[$];
    int    m_ptr = 0;

    function automatic logic [2*W-1:0] ref_z(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic ex);
        longint unsigned aa, bb;
        aa = a;
        bb = b;
        if (!ex) begin
            aa = (aa >> TRUNC) << TRUNC;
            bb = (bb >> TRUNC) << TRUNC;
        end
        return (2*W)'(aa * bb);
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        bit              out_v;
        bit              adv;
        int              g;
        item_t           it;
        if (rst) begin
            n_checks++;
            if (req_ready !== '0) begin
                n_fail++;
                $display("FAIL ready_in_reset: got %b, expected %b", req_ready, {NREQ{1'b0}});
            end
            m_q.delete();
            m_ptr = 0;
        end else begin
            out_v = (m_q.size() > 0) && (m_q[0].age == LAT-1);
            adv   = !(out_v && !rsp_ready);
            g     = -1;
            if (adv) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;

            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL mon_req_ready @%0t: got %b, expected %b", $time, req_ready, exp_ready);
            end
            n_checks++;
            if (rsp_valid !== out_v) begin
                n_fail++;
                $display("FAIL mon_rsp_valid @%0t: got %b, expected %b", $time, rsp_valid, out_v);
            end
            if (out_v) begin
                n_checks++;
                if (rsp_id !== IDW'(m_q[0].id) || rsp_z !== m_q[0].z) begin
                    n_fail++;
                    $display("FAIL mon_rsp_data @%0t: got id %0d z %h, expected id %0d z %h",
                             $time, rsp_id, rsp_z, m_q[0].id, m_q[0].z);
                end
            end
            if (rsp_valid && rsp_ready && rsp_id == IDW'(2)) rsp2_seen++;

            if (adv) begin
                if (out_v) void'(m_q.pop_front());
                foreach (m_q[j]) m_q[j].age++;
                if (g >= 0) begin
                    it.id  = g;
                    it.z   = ref_z(req_a[g*W +: W], req_b[g*W +: W], req_exact[g]);
                    it.age = 0;
                    m_q.push_back(it);
                    m_ptr = (g + 1) % NREQ;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic ex);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_exact[i]    = ex;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 12'h07F;
            2:       return 12'h080;
            3:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic rand_ops(input int i);
        set_req(i, pick(), pick(), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        req_valid = '0;
        rsp_ready = 1'b1;
        cyc = 0;
        while (m_q.size() > 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (m_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", m_q.size());
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: got rsp_valid %b, expected 0", rsp_valid);
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        do_reset(2);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_z !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v %b id %0d z %h, expected 0 0 0", rsp_valid, rsp_id, rsp_z);
        end
        n_checks++;
        if (req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready_idle: got %b, expected 0", req_ready);
        end
        tick();
    endtask

    task automatic send_one(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ex, input logic [2*W-1:0] exp_z, input string name);
        int cyc;
        bit acc;
        set_req(r, a, b, ex);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        rsp_ready    = 1'b1;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 20) begin
            @(negedge clk);
            acc = req_ready[r];
            tick();
            cyc++;
        end
        req_valid[r] = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL %s_accept: got no grant, expected grant to %0d", name, r);
            return;
        end
        cyc = 1;
        @(negedge clk);
        while (!rsp_valid && cyc < 20) begin
            tick();
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (cyc != LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d, expected %0d", name, cyc, LAT);
        end
        n_checks++;
        if (rsp_z !== exp_z) begin
            n_fail++;
            $display("FAIL %s_z: got %h, expected %h", name, rsp_z, exp_z);
        end
        n_checks++;
        if (rsp_id !== IDW'(r)) begin
            n_fail++;
            $display("FAIL %s_id: got %0d, expected %0d", name, rsp_id, r);
        end
        tick();
    endtask

    task automatic test_precision();
        send_one(0, 12'hFFF, 12'hFFF, 1'b0, 24'hF04000, "approx_max");
        send_one(1, 12'hFFF, 12'hFFF, 1'b1, 24'hFFE001, "exact_max");
        send_one(2, 12'h07F, 12'h07F, 1'b0, 24'h000000, "approx_floor");
        send_one(3, 12'h080, 12'h080, 1'b0, 24'h004000, "approx_step");
        send_one(0, 12'h07F, 12'h07F, 1'b1, 24'h003F01, "exact_small");
        send_one(1, 12'h0FF, 12'h081, 1'b0, 24'h004000, "approx_mixed");
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp;
        do_reset(1);
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 2*NREQ; c++) begin
            @(negedge clk);
            exp = NREQ'(1) << (c % NREQ);
            n_checks++;
            if (req_ready !== exp) begin
                n_fail++;
                $display("FAIL rr_all_grant[%0d]: got %b, expected %b", c, req_ready, exp);
            end
            if (c >= LAT) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== IDW'((c - LAT) % NREQ)) begin
                    n_fail++;
                    $display("FAIL rr_rsp_id[%0d]: got v %b id %0d, expected v 1 id %0d",
                             c, rsp_valid, rsp_id, (c - LAT) % NREQ);
                end
            end
            tick();
            rand_ops(c % NREQ);
        end
        req_valid = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp = (c % 2 == 0) ? 4'b0010 : 4'b1000;
            n_checks++;
            if (req_ready !== exp) begin
                n_fail++;
                $display("FAIL rr_sparse_grant[%0d]: got %b, expected %b", c, req_ready, exp);
            end
            tick();
            rand_ops((c % 2 == 0) ? 1 : 3);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [IDW-1:0] hold_id;
        logic [2*W-1:0] hold_z;
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (4) tick();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== '0) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got v %b ready %b, expected v 1 ready 0", k, rsp_valid, req_ready);
            end
            if (k == 0) begin
                hold_id = rsp_id;
                hold_z  = rsp_z;
            end else begin
                n_checks++;
                if (rsp_id !== hold_id || rsp_z !== hold_z) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d]: got id %0d z %h, expected id %0d z %h",
                             k, rsp_id, rsp_z, hold_id, hold_z);
                end
            end
            tick();
        end
        rsp_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_z !== '0 || rsp_id !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got v %b id %0d z %h, expected 0 0 0", rsp_valid, rsp_id, rsp_z);
        end
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_first_grant: got %b, expected 0001", req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_dropped();
        rsp2_seen = 0;
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        req_valid = 4'b1011;
        rsp_ready = 1'b1;
        repeat (4) tick();
        rsp_ready = 1'b0;
        tick();
        req_valid[2] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== '0) begin
                n_fail++;
                $display("FAIL drop_no_grant[%0d]: got %b, expected 0000", k, req_ready);
            end
            tick();
        end
        req_valid[2] = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) tick();
        drain();
        n_checks++;
        if (rsp2_seen != 0) begin
            n_fail++;
            $display("FAIL drop_no_rsp: got %0d responses for id 2, expected 0", rsp2_seen);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] acc;
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !acc[i]) begin
                    // Pending requests hold their operands; occasionally withdraw.
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    rand_ops(i);
                end
            end
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_exact = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_precision();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_dropped();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
